fb_pixel_writer: RTL

- Consumer end of the render pixel interface: takes the x/y/cidx/drawing stream from a render_* module and its draw engine, then writes it into a single-port framebuffer BRAM.
- Clips off-screen pixels and buffers pixels in a small FIFO.
- Throttles the renderer through oe when the framebuffer port is withheld (e.g. during buffer swap), and computes linear addresses.
- Signals frame_done once every pixel of a finished render has been written.

---
 rtl/fb_pkg.sv | 14 +
 rtl/fifo_sync.sv | 54 +++++
 rtl/fb_pixel_writer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared helpers for the framebuffer pixel path: address and coordinate widths.
package fb_pkg;

  // Bits needed to address every pixel of a width x height framebuffer.
  function automatic int fb_addr_width(input int width, input int height);
    return $clog2(width * height);
  endfunction

  // Bits needed to hold an unsigned coordinate in the range 0..extent-1.
  function automatic int coord_width(input int extent);
    return (extent > 1) ? $clog2(extent) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered occupancy count. A push into a full FIFO and
// a pop from an empty FIFO are both ignored, so callers may drive them freely.
module fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because the count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Consumer end of the render pixel stream: clips, buffers, throttles the
// renderer via oe, computes linear framebuffer addresses and reports frame end.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int CORDW    = 16,
  parameter int CIDXW    = 4,
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 180,
  parameter int DEPTH    = 4,
  parameter int FB_ADDRW = fb_addr_width(WIDTH, HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CORDW-1:0] x,
  input  logic signed [CORDW-1:0] y,
  input  logic [CIDXW-1:0]        cidx,
  input  logic                    drawing,
  input  logic                    render_done,
  input  logic                    mem_ready,
  output logic                    oe,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [CIDXW-1:0]        fb_din,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int XW   = coord_width(WIDTH);
  localparam int YW   = coord_width(HEIGHT);
  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic signed [CORDW-1:0] X_LIM      = CORDW'(WIDTH);
  localparam logic signed [CORDW-1:0] Y_LIM      = CORDW'(HEIGHT);
  localparam logic [FB_ADDRW-1:0]     ROW_STRIDE = FB_ADDRW'(WIDTH);

  // Post-clip pixel: coordinates are known non-negative and in range, so only
  // the low bits are kept.
  typedef struct packed {
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [CIDXW-1:0] cidx;
  } pixel_t;

  localparam int PIXW = $bits(pixel_t);

  logic            on_screen;
  logic            push_req;
  logic            pop_fire;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  pixel_t          in_pix;
  pixel_t          head_pix;

  logic                a_valid;
  logic [FB_ADDRW-1:0] a_row_base;
  logic [XW-1:0]       a_x;
  logic [CIDXW-1:0]    a_cidx;
  logic [FB_ADDRW-1:0] row_base_next;

  logic done_pending;
  logic idle;

  // Sign bit clear means non-negative; the upper bounds use a signed compare.
  assign on_screen = !x[CORDW-1] && (x < X_LIM) && !y[CORDW-1] && (y < Y_LIM);
  assign push_req  = drawing && on_screen;
  assign pop_fire  = mem_ready && !fifo_empty;

  assign in_pix.x    = x[XW-1:0];
  assign in_pix.y    = y[YW-1:0];
  assign in_pix.cidx = cidx;

  // One slot of headroom covers the pixel already in flight when oe falls.
  assign oe = (fifo_count <= CNTW'(DEPTH - 2));

  assign row_base_next = FB_ADDRW'(head_pix.y) * ROW_STRIDE;

  assign idle = fifo_empty && !a_valid && !fb_we && !drawing;

  fifo_sync #(
    .W     (PIXW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_fire),
    .din   (in_pix),
    .dout  (head_pix),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky flag for a pixel that had to be dropped because the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Stage A: take the popped pixel and form its row base address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid    <= 1'b0;
      a_row_base <= '0;
      a_x        <= '0;
      a_cidx     <= '0;
    end else begin
      a_valid <= pop_fire;
      if (pop_fire) begin
        a_row_base <= row_base_next;
        a_x        <= head_pix.x;
        a_cidx     <= head_pix.cidx;
      end
    end
  end

  // Stage B: final linear address and write strobe to the framebuffer port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_din  <= '0;
    end else begin
      fb_we <= a_valid;
      if (a_valid) begin
        fb_addr <= a_row_base + FB_ADDRW'(a_x);
        fb_din  <= a_cidx;
      end
    end
  end

  // Hold a render_done until the whole path drains, then emit a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_pending <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (done_pending && idle) begin
        frame_done   <= 1'b1;
        done_pending <= 1'b0;
      end else if (render_done) begin
        done_pending <= 1'b1;
      end
    end
  end

endmodule
